// File: rtl/sdram_request_arbiter_if.sv
// Bundle of requester-side and SDRAM-controller-side signals around the request arbiter.
// The arbiter uses the master view; the requesters and controller model use the slave view.
interface sdram_request_arbiter_if;
    logic        req0;
    logic        req1;
    logic [24:0] addr0;
    logic [24:0] addr1;
    logic [15:0] wdata0;
    logic [15:0] wdata1;
    logic        we0;
    logic        we1;
    logic        done0;
    logic        done1;
    logic        err0;
    logic        err1;
    logic [15:0] rdata0;
    logic [15:0] rdata1;
    logic [24:0] sdram_inputAddress;
    logic [15:0] sdram_writeData;
    logic        sdram_isWriting;
    logic        sdram_inputValid;
    logic [15:0] sdram_readData;
    logic        sdram_outputValid;
    logic        sdram_recievedCommand;
    logic        sdram_isBusy;
    logic [31:0] debugString;

    modport master (
        input  req0, req1, addr0, addr1, wdata0, wdata1, we0, we1,
        input  sdram_readData, sdram_outputValid, sdram_recievedCommand, sdram_isBusy,
        output done0, done1, err0, err1, rdata0, rdata1,
        output sdram_inputAddress, sdram_writeData, sdram_isWriting, sdram_inputValid,
        output debugString
    );

    modport slave (
        output req0, req1, addr0, addr1, wdata0, wdata1, we0, we1,
        output sdram_readData, sdram_outputValid, sdram_recievedCommand, sdram_isBusy,
        input  done0, done1, err0, err1, rdata0, rdata1,
        input  sdram_inputAddress, sdram_writeData, sdram_isWriting, sdram_inputValid,
        input  debugString
    );
endinterface

// File: rtl/sdram_request_arbiter.sv
// Round-robin arbiter sharing the SDRAM controller command port between the
// recording writer (port 0) and the playback reader (port 1).
module sdram_request_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           clock_50Mhz,
    input  logic                           reset,
    sdram_request_arbiter_if.master        bus
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_READ = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    state_t      r_state, w_stateNext;
    logic        r_lastGrant, w_lastGrantNext;
    logic [15:0] r_timeout, w_timeoutNext;
    logic [24:0] r_addr, w_addrNext;
    logic [15:0] r_wdata, w_wdataNext;
    logic        r_isWriting, w_isWritingNext;
    logic        r_inputValid, w_inputValidNext;
    logic        r_done0, w_done0Next;
    logic        r_done1, w_done1Next;
    logic        r_err0, w_err0Next;
    logic        r_err1, w_err1Next;
    logic [15:0] r_rdata0, w_rdata0Next;
    logic [15:0] r_rdata1, w_rdata1Next;
    logic [15:0] r_txCount, w_txCountNext;
    logic [7:0]  r_errCount, w_errCountNext;

    logic        w_winner;
    logic [15:0] w_timeoutInc;
    logic        w_timeoutHit;

    // The port that did not win last time gets the grant whenever it is asking.
    assign w_winner     = r_lastGrant ? !bus.req0 : bus.req1;
    assign w_timeoutInc = r_timeout + 16'd1;
    assign w_timeoutHit = (w_timeoutInc == TIMEOUT_LIMIT);

    always_comb begin
        w_stateNext      = r_state;
        w_lastGrantNext  = r_lastGrant;
        w_timeoutNext    = r_timeout;
        w_addrNext       = r_addr;
        w_wdataNext      = r_wdata;
        w_isWritingNext  = r_isWriting;
        w_inputValidNext = r_inputValid;
        w_rdata0Next     = r_rdata0;
        w_rdata1Next     = r_rdata1;
        w_txCountNext    = r_txCount;
        w_errCountNext   = r_errCount;
        w_done0Next      = 1'b0;
        w_done1Next      = 1'b0;
        w_err0Next       = 1'b0;
        w_err1Next       = 1'b0;

        case (r_state)
            IDLE: begin
                if (!bus.sdram_isBusy && (bus.req0 || bus.req1)) begin
                    w_lastGrantNext  = w_winner;
                    w_addrNext       = w_winner ? bus.addr1  : bus.addr0;
                    w_wdataNext      = w_winner ? bus.wdata1 : bus.wdata0;
                    w_isWritingNext  = w_winner ? bus.we1    : bus.we0;
                    w_inputValidNext = 1'b1;
                    w_timeoutNext    = 16'd0;
                    w_stateNext      = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.sdram_recievedCommand) begin
                    w_inputValidNext = 1'b0;
                    w_timeoutNext    = 16'd0;
                    if (r_isWriting) begin
                        w_done0Next = !r_lastGrant;
                        w_done1Next = r_lastGrant;
                        w_stateNext = DONE;
                    end else begin
                        w_stateNext = WAIT_READ;
                    end
                end else if (w_timeoutHit) begin
                    w_inputValidNext = 1'b0;
                    w_done0Next      = !r_lastGrant;
                    w_done1Next      = r_lastGrant;
                    w_err0Next       = !r_lastGrant;
                    w_err1Next       = r_lastGrant;
                    w_errCountNext   = (r_errCount == 8'hFF) ? r_errCount : r_errCount + 8'd1;
                    w_stateNext      = DONE;
                end else begin
                    w_timeoutNext = w_timeoutInc;
                end
            end
            WAIT_READ: begin
                if (bus.sdram_outputValid) begin
                    if (r_lastGrant) begin
                        w_rdata1Next = bus.sdram_readData;
                    end else begin
                        w_rdata0Next = bus.sdram_readData;
                    end
                    w_done0Next = !r_lastGrant;
                    w_done1Next = r_lastGrant;
                    w_stateNext = DONE;
                end else if (w_timeoutHit) begin
                    w_done0Next    = !r_lastGrant;
                    w_done1Next    = r_lastGrant;
                    w_err0Next     = !r_lastGrant;
                    w_err1Next     = r_lastGrant;
                    w_errCountNext = (r_errCount == 8'hFF) ? r_errCount : r_errCount + 8'd1;
                    w_stateNext    = DONE;
                end else begin
                    w_timeoutNext = w_timeoutInc;
                end
            end
            DONE: begin
                w_txCountNext = r_txCount + 16'd1;
                w_stateNext   = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // last_grant comes out of reset as port 1 so that port 0 is served first.
    always_ff @(posedge clock_50Mhz) begin
        if (reset) begin
            r_state      <= IDLE;
            r_lastGrant  <= 1'b1;
            r_timeout    <= 16'd0;
            r_addr       <= 25'd0;
            r_wdata      <= 16'd0;
            r_isWriting  <= 1'b0;
            r_inputValid <= 1'b0;
            r_done0      <= 1'b0;
            r_done1      <= 1'b0;
            r_err0       <= 1'b0;
            r_err1       <= 1'b0;
            r_rdata0     <= 16'd0;
            r_rdata1     <= 16'd0;
            r_txCount    <= 16'd0;
            r_errCount   <= 8'd0;
        end else begin
            r_state      <= w_stateNext;
            r_lastGrant  <= w_lastGrantNext;
            r_timeout    <= w_timeoutNext;
            r_addr       <= w_addrNext;
            r_wdata      <= w_wdataNext;
            r_isWriting  <= w_isWritingNext;
            r_inputValid <= w_inputValidNext;
            r_done0      <= w_done0Next;
            r_done1      <= w_done1Next;
            r_err0       <= w_err0Next;
            r_err1       <= w_err1Next;
            r_rdata0     <= w_rdata0Next;
            r_rdata1     <= w_rdata1Next;
            r_txCount    <= w_txCountNext;
            r_errCount   <= w_errCountNext;
        end
    end

    assign bus.done0              = r_done0;
    assign bus.done1              = r_done1;
    assign bus.err0               = r_err0;
    assign bus.err1               = r_err1;
    assign bus.rdata0             = r_rdata0;
    assign bus.rdata1             = r_rdata1;
    assign bus.sdram_inputAddress = r_addr;
    assign bus.sdram_writeData    = r_wdata;
    assign bus.sdram_isWriting    = r_isWriting;
    assign bus.sdram_inputValid   = r_inputValid;
    assign bus.debugString        = {r_txCount, r_errCount, 2'b00, r_state, r_lastGrant, 3'b000};
endmodule

// File: tb/tb_sdram_request_arbiter.sv
// Self-checking bench for sdram_request_arbiter: directed vector table, multi-cycle
// corner sequences, and a randomized two-requester run against a round-robin model.
module tb_sdram_request_arbiter;
    localparam int TIMEOUT = 8;
    localparam int NRAND   = 12;

    logic clock_50Mhz = 1'b0;
    logic reset;

    sdram_request_arbiter_if bus();

    sdram_request_arbiter #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clock_50Mhz(clock_50Mhz),
        .reset      (reset),
        .bus        (bus)
    );

    always #10 clock_50Mhz = ~clock_50Mhz;

    typedef struct {
        logic [24:0] addr;
        logic [15:0] wdata;
        logic        we;
    } grant_t;

    typedef struct {
        logic        port;
        logic        err;
        logic [15:0] rdata;
    } done_t;

    typedef struct {
        logic        port;
        logic        we;
        logic [24:0] addr;
        logic [15:0] wdata;
        int          rcDelay;
        int          ovDelay;
        logic        rcNever;
        logic [15:0] readValue;
        int          expIv;
        logic        expErr;
        logic [15:0] expRdata;
        logic [15:0] expTx;
        logic [7:0]  expErrCount;
    } vector_t;

    int          checks = 0;
    int          errors = 0;
    grant_t      grantQ[$];
    done_t       doneQ[$];
    logic [15:0] servedQ[$];
    int          ivRun = 0;
    int          lastIvRun = 0;
    int          rcDelay = 0;
    int          ovDelay = 1;
    int          ovCount = 0;
    logic        rcNever = 1'b0;
    logic        readPending = 1'b0;
    logic [15:0] readValue = 16'h0;
    logic        edgeReq0, edgeReq1, edgeBusy;
    logic        modelLast;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic driveReq(input logic p, input logic level, input logic [24:0] a,
                            input logic [15:0] d, input logic w);
        if (p) begin
            bus.req1 = level; bus.addr1 = a; bus.wdata1 = d; bus.we1 = w;
        end else begin
            bus.req0 = level; bus.addr0 = a; bus.wdata0 = d; bus.we0 = w;
        end
    endtask

    // One clock: record what the DUT shows after the edge, then play the controller.
    task automatic tick();
        edgeReq0 = bus.req0;
        edgeReq1 = bus.req1;
        edgeBusy = bus.sdram_isBusy;
        @(posedge clock_50Mhz);
        #1;
        if (bus.sdram_inputValid === 1'b1) begin
            if (ivRun == 0) grantQ.push_back('{bus.sdram_inputAddress, bus.sdram_writeData, bus.sdram_isWriting});
            ivRun++;
        end else if (ivRun != 0) begin
            lastIvRun = ivRun;
            ivRun = 0;
        end
        if (bus.done0 === 1'b1) doneQ.push_back('{1'b0, bus.err0, bus.rdata0});
        if (bus.done1 === 1'b1) doneQ.push_back('{1'b1, bus.err1, bus.rdata1});
        bus.sdram_outputValid = 1'b0;
        if (bus.sdram_inputValid === 1'b1) begin
            if (!rcNever && ivRun == rcDelay + 1) begin
                bus.sdram_recievedCommand = 1'b1;
                readPending = !bus.sdram_isWriting;
                ovCount = 0;
            end
        end else begin
            bus.sdram_recievedCommand = 1'b0;
            if (readPending) begin
                ovCount++;
                if (ovCount == ovDelay) begin
                    bus.sdram_outputValid = 1'b1;
                    bus.sdram_readData = readValue;
                    servedQ.push_back(readValue);
                    readPending = 1'b0;
                    readValue = 16'($urandom);
                end
            end
        end
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        while (doneQ.size() == 0 && n < budget) begin
            tick();
            n++;
        end
        if (doneQ.size() == 0) checkOutput("done_wait_expired", 0, 1);
    endtask

    task automatic applyStimulus(input vector_t v, input int idx);
        grant_t g;
        done_t  d;
        grantQ.delete();
        doneQ.delete();
        rcDelay   = v.rcDelay;
        ovDelay   = v.ovDelay;
        rcNever   = v.rcNever;
        readValue = v.readValue;
        driveReq(v.port, 1'b1, v.addr, v.wdata, v.we);
        waitDone(60);
        driveReq(v.port, 1'b0, v.addr, v.wdata, v.we);
        rcNever = 1'b0;
        tick();
        modelLast = v.port;
        checkOutput($sformatf("vec%0d_grants", idx), grantQ.size(), 1);
        if (grantQ.size() > 0) begin
            g = grantQ.pop_front();
            checkOutput($sformatf("vec%0d_addr", idx), g.addr, v.addr);
            checkOutput($sformatf("vec%0d_wdata", idx), g.wdata, v.wdata);
            checkOutput($sformatf("vec%0d_isWriting", idx), g.we, v.we);
        end
        checkOutput($sformatf("vec%0d_ivCycles", idx), lastIvRun, v.expIv);
        checkOutput($sformatf("vec%0d_doneCount", idx), doneQ.size(), 1);
        if (doneQ.size() > 0) begin
            d = doneQ.pop_front();
            checkOutput($sformatf("vec%0d_donePort", idx), d.port, v.port);
            checkOutput($sformatf("vec%0d_err", idx), d.err, v.expErr);
            checkOutput($sformatf("vec%0d_rdata", idx), d.rdata, v.expRdata);
        end
        checkOutput($sformatf("vec%0d_debug", idx), bus.debugString,
                    {v.expTx, v.expErrCount, 4'h0, v.port, 3'b000});
    endtask

    vector_t vecs[6];
    grant_t  txn[2][NRAND];
    grant_t  g;
    done_t   d;
    int      n, violations, altBad, cnt0, cnt1;
    int      idx[2];
    logic    w, expW, preferred, inFlight;

    initial begin
        // port, we, addr, wdata, rcDelay, ovDelay, rcNever, readValue, expIv, expErr, expRdata, expTx, expErrCount
        vecs[0] = '{1'b0, 1'b1, 25'h0000010, 16'h0080, 2, 1, 1'b0, 16'h0000, 3, 1'b0, 16'h0000, 16'd1, 8'd0};
        vecs[1] = '{1'b1, 1'b0, 25'h01ABCDE, 16'h0000, 1, 4, 1'b0, 16'h1234, 2, 1'b0, 16'h1234, 16'd2, 8'd0};
        vecs[2] = '{1'b1, 1'b0, 25'h0F0F0F0, 16'h0000, 0, 1, 1'b1, 16'hAAAA, 8, 1'b1, 16'h1234, 16'd3, 8'd1};
        vecs[3] = '{1'b0, 1'b0, 25'h0155555, 16'h3C3C, 0, 1, 1'b0, 16'hBEEF, 1, 1'b0, 16'hBEEF, 16'd4, 8'd1};
        vecs[4] = '{1'b1, 1'b1, 25'h1FFFFFF, 16'hFFFF, 4, 1, 1'b0, 16'h0000, 5, 1'b0, 16'h1234, 16'd5, 8'd1};
        vecs[5] = '{1'b0, 1'b0, 25'h0000777, 16'h0001, 0, 1, 1'b1, 16'h5555, 8, 1'b1, 16'hBEEF, 16'd6, 8'd2};

        reset = 1'b1;
        driveReq(1'b0, 1'b0, 25'h0, 16'h0, 1'b0);
        driveReq(1'b1, 1'b0, 25'h0, 16'h0, 1'b0);
        bus.sdram_readData = 16'h0;
        bus.sdram_outputValid = 1'b0;
        bus.sdram_recievedCommand = 1'b0;
        bus.sdram_isBusy = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        checkOutput("reset_flags", {bus.done0, bus.done1, bus.err0, bus.err1,
                                    bus.sdram_inputValid, bus.sdram_isWriting}, 6'b0);
        checkOutput("reset_addr", bus.sdram_inputAddress, 25'h0);
        checkOutput("reset_wdata", bus.sdram_writeData, 16'h0);
        checkOutput("reset_rdata", {bus.rdata0, bus.rdata1}, 32'h0);
        checkOutput("reset_debug", bus.debugString, 32'h0000_0008);
        grantQ.delete();
        doneQ.delete();

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i], i);

        // isBusy holds off the grant until the first edge where it is low.
        grantQ.delete();
        doneQ.delete();
        rcDelay = 0;
        bus.sdram_isBusy = 1'b1;
        driveReq(1'b0, 1'b1, 25'h0000ABC, 16'h5A5A, 1'b1);
        violations = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.sdram_inputValid !== 1'b0) violations++;
        end
        checkOutput("busy_hold_iv", violations, 0);
        bus.sdram_isBusy = 1'b0;
        tick();
        checkOutput("busy_release_grant", bus.sdram_inputValid, 1'b1);
        waitDone(30);
        driveReq(1'b0, 1'b0, 25'h0000ABC, 16'h5A5A, 1'b1);
        tick();
        checkOutput("busy_done_count", doneQ.size(), 1);
        modelLast = 1'b0;

        // Both ports held high for four transactions each must alternate.
        grantQ.delete();
        doneQ.delete();
        driveReq(1'b0, 1'b1, 25'h0000100, 16'h1111, 1'b1);
        driveReq(1'b1, 1'b1, 25'h1000200, 16'h2222, 1'b1);
        cnt0 = 0; cnt1 = 0; altBad = 0; n = 0;
        while ((cnt0 < 4 || cnt1 < 4) && n < 400) begin
            tick();
            n++;
            while (grantQ.size() > 0) begin
                g = grantQ.pop_front();
                if (g.addr[24] == modelLast) altBad++;
                modelLast = g.addr[24];
            end
            while (doneQ.size() > 0) begin
                d = doneQ.pop_front();
                if (d.port) begin
                    cnt1++;
                    if (cnt1 >= 4) bus.req1 = 1'b0;
                end else begin
                    cnt0++;
                    if (cnt0 >= 4) bus.req0 = 1'b0;
                end
            end
        end
        checkOutput("cont_alternate", altBad, 0);
        checkOutput("cont_done0", cnt0, 4);
        checkOutput("cont_done1", cnt1, 4);
        for (int i = 0; i < 5; i++) tick();
        checkOutput("cont_no_extra", grantQ.size() + doneQ.size(), 0);

        // Reset while a read is waiting for data abandons it silently.
        grantQ.delete();
        doneQ.delete();
        rcDelay = 0;
        ovDelay = 6;
        driveReq(1'b1, 1'b1, 25'h1000055, 16'h0, 1'b0);
        n = 0;
        while (bus.debugString[7:4] != 4'd2 && n < 20) begin
            tick();
            n++;
        end
        checkOutput("rst_reached_wait_read", bus.debugString[7:4], 4'd2);
        reset = 1'b1;
        driveReq(1'b1, 1'b0, 25'h1000055, 16'h0, 1'b0);
        tick();
        reset = 1'b0;
        readPending = 1'b0;
        bus.sdram_recievedCommand = 1'b0;
        checkOutput("rst_flags", {bus.done0, bus.done1, bus.err0, bus.err1,
                                  bus.sdram_inputValid, bus.sdram_isWriting}, 6'b0);
        checkOutput("rst_addr", bus.sdram_inputAddress, 25'h0);
        checkOutput("rst_rdata", {bus.rdata0, bus.rdata1}, 32'h0);
        checkOutput("rst_debug", bus.debugString, 32'h0000_0008);
        for (int i = 0; i < 8; i++) tick();
        checkOutput("rst_no_done", doneQ.size(), 0);
        grantQ.delete();
        driveReq(1'b0, 1'b1, 25'h0000066, 16'h7777, 1'b1);
        driveReq(1'b1, 1'b1, 25'h1000066, 16'h8888, 1'b1);
        n = 0;
        while (grantQ.size() == 0 && n < 20) begin
            tick();
            n++;
        end
        driveReq(1'b1, 1'b0, 25'h1000066, 16'h8888, 1'b1);
        checkOutput("rst_first_grant_port", (grantQ.size() > 0) ? {31'd0, grantQ[0].addr[24]} : 32'hFFFF, 0);
        waitDone(30);
        driveReq(1'b0, 1'b0, 25'h0000066, 16'h7777, 1'b1);
        tick();
        modelLast = 1'b0;

        // Randomized traffic on both ports checked against the round-robin rules.
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < NRAND; i++) begin
                txn[p][i].addr  = {p[0], 24'($urandom)};
                txn[p][i].wdata = 16'($urandom);
                txn[p][i].we    = 1'($urandom_range(1));
            end
            idx[p] = 0;
        end
        grantQ.delete();
        doneQ.delete();
        servedQ.delete();
        rcDelay = 1;
        ovDelay = 2;
        inFlight = 1'b0;
        n = 0;
        while ((idx[0] < NRAND || idx[1] < NRAND) && n < 4000) begin
            if (!bus.req0 && idx[0] < NRAND && $urandom_range(2) == 0)
                driveReq(1'b0, 1'b1, txn[0][idx[0]].addr, txn[0][idx[0]].wdata, txn[0][idx[0]].we);
            if (!bus.req1 && idx[1] < NRAND && $urandom_range(2) == 0)
                driveReq(1'b1, 1'b1, txn[1][idx[1]].addr, txn[1][idx[1]].wdata, txn[1][idx[1]].we);
            bus.sdram_isBusy = ($urandom_range(3) == 0);
            tick();
            n++;
            while (grantQ.size() > 0) begin
                g = grantQ.pop_front();
                w = g.addr[24];
                checkOutput("rnd_grant_legal", (edgeReq0 || edgeReq1) && !edgeBusy, 1'b1);
                preferred = !modelLast;
                expW = (preferred ? edgeReq1 : edgeReq0) ? preferred : !preferred;
                checkOutput("rnd_winner", w, expW);
                if (idx[w] < NRAND) begin
                    checkOutput("rnd_grant_addr", g.addr, txn[w][idx[w]].addr);
                    checkOutput("rnd_grant_wdata", g.wdata, txn[w][idx[w]].wdata);
                    checkOutput("rnd_grant_we", g.we, txn[w][idx[w]].we);
                end else begin
                    checkOutput("rnd_unexpected_grant", 0, 1);
                end
                modelLast = w;
                inFlight  = w;
            end
            while (doneQ.size() > 0) begin
                d = doneQ.pop_front();
                checkOutput("rnd_done_port", d.port, inFlight);
                checkOutput("rnd_done_err", d.err, 1'b0);
                if (idx[d.port] < NRAND) begin
                    if (!txn[d.port][idx[d.port]].we) begin
                        checkOutput("rnd_read_served", servedQ.size() > 0, 1'b1);
                        if (servedQ.size() > 0) checkOutput("rnd_rdata", d.rdata, servedQ.pop_front());
                    end
                    idx[d.port]++;
                end
                rcDelay = $urandom_range(4);
                ovDelay = $urandom_range(5, 1);
                if (idx[d.port] < NRAND && $urandom_range(1) == 1)
                    driveReq(d.port, 1'b1, txn[d.port][idx[d.port]].addr,
                             txn[d.port][idx[d.port]].wdata, txn[d.port][idx[d.port]].we);
                else
                    driveReq(d.port, 1'b0, 25'h0, 16'h0, 1'b0);
            end
        end
        bus.sdram_isBusy = 1'b0;
        checkOutput("rnd_complete0", idx[0], NRAND);
        checkOutput("rnd_complete1", idx[1], NRAND);
        tick();
        tick();
        checkOutput("rnd_tx_count", bus.debugString[31:16], 16'(1 + 2 * NRAND));
        checkOutput("rnd_err_count", bus.debugString[15:8], 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
